// File: rtl/key_search_scheduler.sv
// Hands out candidate keys to a pool of decryption cores round-robin and
// reports either the first key that decrypts to valid text or exhaustion.
module key_search_scheduler #(
  parameter int                CORES     = 4,
  parameter int                KEY_W     = 24,
  parameter logic [KEY_W-1:0]  START_KEY = '0,
  parameter logic [KEY_W-1:0]  KEY_MAX   = 24'h3FFFFF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic [CORES-1:0]  core_ready,
  input  logic [CORES-1:0]  core_done,
  input  logic [CORES-1:0]  core_found,
  output logic [CORES-1:0]  core_start,
  output logic [KEY_W-1:0]  core_key,
  output logic              core_abort,
  output logic              busy,
  output logic              found,
  output logic              not_found,
  output logic [KEY_W-1:0]  found_key
);

  localparam int IDX_W = (CORES > 1) ? $clog2(CORES) : 1;

  typedef enum logic [2:0] {IDLE, DISPATCH, DRAIN, FOUND, EXHAUSTED} state_t;

  state_t             state, state_d;
  logic [KEY_W-1:0]   next_key;
  logic [CORES-1:0]   outstanding;
  logic [IDX_W-1:0]   rr;
  logic [KEY_W-1:0]   key_q [CORES];

  logic               active, restart, dispatch;
  logic [CORES-1:0]   eligible, hit_vec;
  logic               pick_valid, hit_valid;
  logic [IDX_W-1:0]   pick_idx, hit_idx, idx;

  assign active   = (state == DISPATCH) || (state == DRAIN);
  assign busy     = active;
  assign restart  = start && !active;
  assign eligible = core_ready & ~outstanding;
  // Only a core that actually holds a key can report a hit.
  assign hit_vec  = core_done & core_found & outstanding;

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves a value held and no latch is inferred.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = '0;
    for (int off = 0; off < CORES; off++) begin
      idx = IDX_W'((int'(rr) + off) % CORES);
      if (!pick_valid && eligible[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  // Scan downwards so the lowest-index hitting core wins.
  always_comb begin
    hit_idx = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IDX_W'(i);
    end
  end

  assign hit_valid = active && (hit_vec != '0);
  assign dispatch  = (state == DISPATCH) && pick_valid && !hit_valid;

  always_comb begin
    core_start = '0;
    core_key   = '0;
    if (dispatch) begin
      core_start[pick_idx] = 1'b1;
      core_key             = next_key;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, FOUND, EXHAUSTED: if (start) state_d = DISPATCH;
      DISPATCH: begin
        if (hit_valid)                              state_d = FOUND;
        else if (dispatch && next_key == KEY_MAX)   state_d = DRAIN;
      end
      DRAIN: begin
        if (hit_valid)                  state_d = FOUND;
        else if (outstanding == '0)     state_d = EXHAUSTED;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      next_key    <= START_KEY;
      outstanding <= '0;
      rr          <= '0;
      found       <= 1'b0;
      not_found   <= 1'b0;
      found_key   <= '0;
      core_abort  <= 1'b0;
    end else begin
      state      <= state_d;
      core_abort <= 1'b0;
      if (restart) begin
        found       <= 1'b0;
        not_found   <= 1'b0;
        outstanding <= '0;
        next_key    <= START_KEY;
      end else begin
        outstanding <= (outstanding & ~core_done) | core_start;
        if (dispatch) begin
          rr <= (pick_idx == IDX_W'(CORES - 1)) ? '0 : pick_idx + 1'b1;
          if (next_key != KEY_MAX) next_key <= next_key + 1'b1;
        end
        if (hit_valid) begin
          found      <= 1'b1;
          found_key  <= key_q[hit_idx];
          core_abort <= 1'b1;
        end
        if (state == DRAIN && state_d == EXHAUSTED) not_found <= 1'b1;
      end
    end
  end

  // NOTE: key_q is deliberately not reset; an entry is only read while its
  // outstanding flag is set, and that flag is set on the same edge it is written.
  always_ff @(posedge CLOCK_50) begin
    if (dispatch) key_q[pick_idx] <= next_key;
  end

endmodule

// File: tb/tb_key_search_scheduler.sv
// Directed bench for key_search_scheduler: a behavioural core pool answers
// each dispatched key after a fixed latency; outcomes are compared to hand-derived values.
module tb_key_search_scheduler;

  localparam int CORES = 4;
  localparam int KEY_W = 8;
  localparam int MAXC  = 200;

  logic CLOCK_50 = 1'b0;
  logic reset, start, sel;
  logic [CORES-1:0] core_ready, core_done, core_found;
  logic [CORES-1:0] cs_a, cs_b, core_start;
  logic [KEY_W-1:0] ck_a, ck_b, core_key, fk_a, fk_b, found_key;
  logic ab_a, ab_b, bz_a, bz_b, fd_a, fd_b, nf_a, nf_b;
  logic core_abort, busy, found, not_found;

  int vectors = 0;
  int miscompares = 0;

  int log_core [MAXC];
  int log_key  [MAXC];
  int n_starts, n_abort, onehot_err, hit_cyc, post_starts, busy0;
  bit m_busy [CORES];
  int m_cnt  [CORES];
  int m_key  [CORES];

  always #10 CLOCK_50 = ~CLOCK_50;

  // dut_a: 8-key space for exhaustion-style tests; dut_b: 16 keys for the dual-hit case.
  key_search_scheduler #(.CORES(CORES), .KEY_W(KEY_W), .START_KEY(8'd0), .KEY_MAX(8'd7)) dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start & ~sel),
    .core_ready(core_ready), .core_done(core_done), .core_found(core_found),
    .core_start(cs_a), .core_key(ck_a), .core_abort(ab_a), .busy(bz_a),
    .found(fd_a), .not_found(nf_a), .found_key(fk_a));

  key_search_scheduler #(.CORES(CORES), .KEY_W(KEY_W), .START_KEY(8'd0), .KEY_MAX(8'd15)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start & sel),
    .core_ready(core_ready), .core_done(core_done), .core_found(core_found),
    .core_start(cs_b), .core_key(ck_b), .core_abort(ab_b), .busy(bz_b),
    .found(fd_b), .not_found(nf_b), .found_key(fk_b));

  assign core_start = sel ? cs_b : cs_a;
  assign core_key   = sel ? ck_b : ck_a;
  assign core_abort = sel ? ab_b : ab_a;
  assign busy       = sel ? bz_b : bz_a;
  assign found      = sel ? fd_b : fd_a;
  assign not_found  = sel ? nf_b : nf_a;
  assign found_key  = sel ? fk_b : fk_a;

  function automatic bit is_hit(int k, int a, int b);
    return (k == a) || (k == b);
  endfunction

  // Number of keys in 0..kmax not issued exactly once in the last run.
  function automatic int key_errors(int kmax);
    int bad, cnt;
    bad = 0;
    for (int k = 0; k <= kmax; k++) begin
      cnt = 0;
      for (int c = 0; c < MAXC; c++) if (log_key[c] == k) cnt++;
      if (cnt != 1) bad++;
    end
    return bad;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    core_done = '0;
    core_found = '0;
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b0;
  endtask

  // Pulses start, then emulates the cores cycle by cycle. Inputs change at
  // posedge+1, outputs are sampled at the negedge. With hold set, cores holding
  // a hit key wait until every hit key is out, then all report together.
  task automatic run_search(input int lat, input logic [CORES-1:0] ready, input int hit_a,
                            input int hit_b, input bit hold, input int restart_cyc,
                            input int stop_cyc);
    int cyc, post, nheld, nhits;
    bit term;
    for (int c = 0; c < MAXC; c++) begin log_core[c] = -1; log_key[c] = -1; end
    for (int i = 0; i < CORES; i++) begin m_busy[i] = 1'b0; m_cnt[i] = 0; m_key[i] = 0; end
    n_starts = 0; n_abort = 0; onehot_err = 0; hit_cyc = -1; post_starts = 0; busy0 = 0;
    term = 1'b0; post = 0; cyc = 0;
    nhits = int'(hit_a >= 0) + int'(hit_b >= 0);
    core_ready = ready; core_done = '0; core_found = '0;
    @(negedge CLOCK_50) start = 1'b1;
    @(posedge CLOCK_50) #1 start = 1'b0;
    while (post < 6 && cyc < MAXC && cyc != stop_cyc) begin
      core_done = '0; core_found = '0; nheld = 0;
      for (int i = 0; i < CORES; i++)
        if (m_busy[i] && hold && is_hit(m_key[i], hit_a, hit_b)) nheld++;
      for (int i = 0; i < CORES; i++) begin
        if (m_busy[i]) begin
          if (hold && is_hit(m_key[i], hit_a, hit_b)) begin
            if (nheld == nhits) begin core_done[i] = 1'b1; core_found[i] = 1'b1; m_busy[i] = 1'b0; end
          end else begin
            m_cnt[i]--;
            if (m_cnt[i] == 0) begin
              core_done[i] = 1'b1;
              core_found[i] = is_hit(m_key[i], hit_a, hit_b);
              m_busy[i] = 1'b0;
            end
          end
        end
      end
      if ((core_done & core_found) != '0 && hit_cyc < 0) hit_cyc = cyc;
      start = (cyc == restart_cyc);
      @(negedge CLOCK_50);
      if (cyc == 0) busy0 = int'(busy);
      if ($countones(core_start) > 1) onehot_err++;
      if (core_start != '0) begin
        n_starts++;
        if (hit_cyc >= 0) post_starts++;
        for (int i = 0; i < CORES; i++) begin
          if (core_start[i]) begin
            log_core[cyc] = i; log_key[cyc] = int'(core_key);
            m_busy[i] = 1'b1; m_cnt[i] = lat; m_key[i] = int'(core_key);
          end
        end
      end
      if (core_abort) n_abort++;
      if (term) post++;
      else if (found || not_found) term = 1'b1;
      @(posedge CLOCK_50) #1;
      cyc++;
    end
    start = 1'b0; core_done = '0; core_found = '0;
    if (stop_cyc < 0) begin
      vectors++;
      if (!term) begin miscompares++; $display("FAIL search_timeout: no found/not_found within %0d cycles", MAXC); end
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      vectors++;
      if ({core_start, core_abort, busy, found, not_found, core_key, found_key} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d: got start=%b abort=%b busy=%b found=%b nf=%b key=%0d fkey=%0d, want all 0",
                 s, core_start, core_abort, busy, found, not_found, core_key, found_key);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_exhaustion();
    sel = 1'b0; do_reset();
    run_search(3, 4'b1111, -1, -1, 1'b0, -1, -1);
    vectors++; if (log_core[0] !== 0 || log_key[0] !== 0) begin miscompares++;
      $display("FAIL exh_first_start: got core %0d key %0d, want core 0 key 0", log_core[0], log_key[0]); end
    vectors++; if (busy0 !== 1) begin miscompares++; $display("FAIL exh_busy: got %0d, want 1", busy0); end
    vectors++; if (n_starts !== 8) begin miscompares++; $display("FAIL exh_starts: got %0d, want 8", n_starts); end
    vectors++; if (key_errors(7) !== 0) begin miscompares++; $display("FAIL exh_keys_once: got %0d bad keys, want 0", key_errors(7)); end
    vectors++; if (onehot_err !== 0) begin miscompares++; $display("FAIL exh_onehot: got %0d, want 0", onehot_err); end
    vectors++; if ({not_found, found, busy, core_abort} !== 4'b1000) begin miscompares++;
      $display("FAIL exh_end: got nf/found/busy/abort=%b, want 1000", {not_found, found, busy, core_abort}); end
    vectors++; if (n_abort !== 0) begin miscompares++; $display("FAIL exh_abort: got %0d, want 0", n_abort); end
  endtask

  task automatic test_single_hit();
    sel = 1'b0; do_reset();
    // Core 3 idle and latency 2 steer key 5 onto core 2.
    run_search(2, 4'b0111, 5, -1, 1'b0, -1, -1);
    vectors++; if (log_core[5] !== 2 || log_key[5] !== 5) begin miscompares++;
      $display("FAIL hit_dispatch: got core %0d key %0d at cycle 5, want core 2 key 5", log_core[5], log_key[5]); end
    vectors++; if ({found, not_found, busy} !== 3'b100) begin miscompares++;
      $display("FAIL hit_flags: got found/nf/busy=%b, want 100", {found, not_found, busy}); end
    vectors++; if (found_key !== 8'd5) begin miscompares++; $display("FAIL hit_key: got %0d, want 5", found_key); end
    vectors++; if (n_abort !== 1) begin miscompares++; $display("FAIL hit_abort: got %0d pulses, want 1", n_abort); end
    vectors++; if (post_starts !== 0) begin miscompares++; $display("FAIL hit_no_start: got %0d starts after hit, want 0", post_starts); end
  endtask

  task automatic test_simultaneous_hits();
    sel = 1'b1; do_reset();
    run_search(1, 4'b1111, 9, 11, 1'b1, -1, -1);
    vectors++; if (log_core[9] !== 1 || log_core[11] !== 3) begin miscompares++;
      $display("FAIL dual_dispatch: got cores %0d/%0d for keys 9/11, want 1/3", log_core[9], log_core[11]); end
    vectors++; if (found !== 1'b1 || found_key !== 8'd9) begin miscompares++;
      $display("FAIL dual_key: got found=%b key=%0d, want found=1 key=9", found, found_key); end
    vectors++; if (post_starts !== 0 || n_abort !== 1) begin miscompares++;
      $display("FAIL dual_stop: got %0d late starts, %0d aborts, want 0 and 1", post_starts, n_abort); end
    sel = 1'b0;
  endtask

  task automatic test_ready_gating();
    int c0;
    sel = 1'b0; do_reset();
    run_search(2, 4'b1110, -1, -1, 1'b0, -1, -1);
    c0 = 0;
    for (int c = 0; c < MAXC; c++) if (log_core[c] == 0) c0++;
    vectors++; if (c0 !== 0) begin miscompares++; $display("FAIL gate_core0: got %0d starts on core 0, want 0", c0); end
    vectors++; if (n_starts !== 8 || key_errors(7) !== 0) begin miscompares++;
      $display("FAIL gate_keys: got %0d starts %0d bad keys, want 8 and 0", n_starts, key_errors(7)); end
    vectors++; if (not_found !== 1'b1) begin miscompares++; $display("FAIL gate_nf: got %b, want 1", not_found); end
  endtask

  task automatic test_ignored_start();
    sel = 1'b0; do_reset();
    run_search(10, 4'b1111, -1, -1, 1'b0, 2, -1);
    vectors++; if (log_core[3] !== 3 || log_key[3] !== 3) begin miscompares++;
      $display("FAIL busy_start_key: got core %0d key %0d at cycle 3, want core 3 key 3", log_core[3], log_key[3]); end
    vectors++; if (log_core[4] !== -1) begin miscompares++;
      $display("FAIL busy_start_outstanding: got core %0d at cycle 4, want none", log_core[4]); end
    vectors++; if (n_starts !== 8 || key_errors(7) !== 0) begin miscompares++;
      $display("FAIL busy_start_keys: got %0d starts %0d bad keys, want 8 and 0", n_starts, key_errors(7)); end
  endtask

  task automatic test_reset_restart();
    sel = 1'b0;
    run_search(20, 4'b1111, -1, -1, 1'b0, -1, 3);
    #4;
    vectors++; if (busy !== 1'b1 || core_start !== 4'b1000) begin miscompares++;
      $display("FAIL rst_pre: got busy=%b start=%b, want 1 and 1000", busy, core_start); end
    reset = 1'b1;
    #1;
    vectors++;
    if ({core_start, core_abort, busy, found, not_found, core_key, found_key} !== '0) begin
      miscompares++;
      $display("FAIL rst_async: got start=%b abort=%b busy=%b found=%b nf=%b key=%0d fkey=%0d, want all 0",
               core_start, core_abort, busy, found, not_found, core_key, found_key);
    end
    #2 reset = 1'b0;
    run_search(1, 4'b1111, -1, -1, 1'b0, -1, -1);
    vectors++; if (log_core[0] !== 0 || log_key[0] !== 0) begin miscompares++;
      $display("FAIL rst_restart: got core %0d key %0d, want core 0 key 0", log_core[0], log_key[0]); end
    vectors++; if (n_starts !== 8 || not_found !== 1'b1) begin miscompares++;
      $display("FAIL rst_rerun: got %0d starts nf=%b, want 8 and 1", n_starts, not_found); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sel = 1'b0;
    core_ready = '0; core_done = '0; core_found = '0;
    @(posedge CLOCK_50);
    test_reset();
    test_exhaustion();
    test_single_hit();
    test_simultaneous_hits();
    test_ready_gating();
    test_ignored_start();
    test_reset_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
